systolic_feeder: RTL and testbench

//  Upstream operand sequencer for the 2x2 systolic MAC array.
//  - Accepts a job of K operand beats over a valid/ready stream and buffers them.

---
 rtl/systolic_feeder_if.sv | 23 ++
 rtl/systolic_feeder.sv | 160 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// Operand beat stream into the systolic feeder: one column of A and one
// row of B per beat, with valid/ready handshake and end-of-job marker.
interface systolic_feeder_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a0;
  logic [DW-1:0] in_a1;
  logic [DW-1:0] in_b0;
  logic [DW-1:0] in_b1;
  logic          in_last;

  modport master (
    output in_valid, in_a0, in_a1, in_b0, in_b1, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a0, in_a1, in_b0, in_b1, in_last,
    output in_ready
  );
endinterface

// File: rtl/systolic_feeder.sv
// Operand sequencer for the 2x2 systolic MAC array: buffers a job of K beats,
// clears the accumulators, replays the beats with en_mac, waits for the array
// to settle and pulses done. Every output is driven straight from a flop.
module systolic_feeder #(
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  systolic_feeder_if.slave           in_if,
  output logic [DW-1:0]              a0,
  output logic [DW-1:0]              a1,
  output logic [DW-1:0]              b0,
  output logic [DW-1:0]              b1,
  output logic                       en_mac,
  output logic                       acc_clr,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] k_count
);

  localparam int KW  = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DCW = $clog2(MAC_LAT + 2);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [KW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [KW-1:0]    k_count_q, k_count_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [4*DW-1:0]  mem_q [DEPTH];
  logic [4*DW-1:0]  rd_beat;
  logic             accept;

  logic             in_ready_q;
  logic             busy_q, acc_clr_q, en_mac_q, done_q;
  logic [DW-1:0]    a0_q, a1_q, b0_q, b1_q;

  assign in_if.in_ready = in_ready_q;
  assign a0      = a0_q;
  assign a1      = a1_q;
  assign b0      = b0_q;
  assign b1      = b1_q;
  assign en_mac  = en_mac_q;
  assign acc_clr = acc_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign k_count = k_count_q;

  // rd_ptr is 0 in CLEAR, so the same lookup serves the first RUN beat and the rest
  assign rd_beat = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state, pointer and beat-count logic
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    k_count_d = k_count_q;
    drain_d   = drain_q;
    accept    = 1'b0;
    case (state_q)
      S_LOAD: begin
        accept = in_if.in_valid && in_ready_q;
        if (accept) begin
          wr_ptr_d  = wr_ptr_q + 1'b1;
          k_count_d = k_count_q + 1'b1;
          if (in_if.in_last || (k_count_q == KW'(DEPTH - 1))) begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        state_d  = S_RUN;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      S_RUN: begin
        if (rd_ptr_q == k_count_q) begin
          state_d = (MAC_LAT == 0) ? S_DONE : S_DRAIN;
          drain_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DCW'(MAC_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d   = S_LOAD;
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        k_count_d = '0;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State, pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      k_count_q <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      k_count_q <= k_count_d;
      drain_q   <= drain_d;
    end
  end

  // Operand buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {in_if.in_a0, in_if.in_a1, in_if.in_b0, in_if.in_b1};
    end
  end

  // Registered outputs decoded from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      acc_clr_q  <= 1'b0;
      en_mac_q   <= 1'b0;
      done_q     <= 1'b0;
      a0_q       <= '0;
      a1_q       <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
    end else begin
      in_ready_q <= (state_d == S_LOAD);
      busy_q     <= (state_d != S_LOAD);
      acc_clr_q  <= (state_d == S_CLEAR);
      en_mac_q   <= (state_d == S_RUN);
      done_q     <= (state_d == S_DONE);
      if (state_d == S_RUN) begin
        {a0_q, a1_q, b0_q, b1_q} <= rd_beat;
      end else begin
        {a0_q, a1_q, b0_q, b1_q} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a timeline model expands each completed job into
// its CLEAR/RUN/DRAIN/DONE output sequence and is compared every cycle; a
// behavioural 2x2 array accumulates the DUT operands and is checked at done.
module tb_systolic_feeder;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int MAC_LAT = 1;
  localparam int KW      = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          in_ready;
    logic          busy;
    logic          acc_clr;
    logic          en_mac;
    logic          done;
    logic [KW-1:0] k;
    logic [DW-1:0] a0;
    logic [DW-1:0] a1;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] a0, a1, b0, b1;
  logic          en_mac, acc_clr, busy, done;
  logic [KW-1:0] k_count;

  systolic_feeder_if #(.DW(DW)) in_if ();

  systolic_feeder #(.DW(DW), .DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_if   (in_if),
    .a0      (a0),
    .a1      (a1),
    .b0      (b0),
    .b1      (b1),
    .en_mac  (en_mac),
    .acc_clr (acc_clr),
    .busy    (busy),
    .done    (done),
    .k_count (k_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- timeline reference model ----------------
  logic [4*DW-1:0] job[$];
  vec_t            sched[$];
  vec_t            cur;
  bit              started = 0;
  logic [15:0]     mp00, mp01, mp10, mp11;

  function automatic vec_t idle_vec(int n);
    vec_t v = '0;
    v.in_ready = 1'b1;
    v.k        = KW'(n);
    return v;
  endfunction

  // Expand a completed job into the cycles it must produce
  function automatic void build_job();
    vec_t v;
    int   kk = job.size();
    mp00 = '0; mp01 = '0; mp10 = '0; mp11 = '0;
    v = '0; v.busy = 1'b1; v.k = KW'(kk); v.acc_clr = 1'b1;
    sched.push_back(v);
    foreach (job[i]) begin
      v = '0; v.busy = 1'b1; v.k = KW'(kk); v.en_mac = 1'b1;
      {v.a0, v.a1, v.b0, v.b1} = job[i];
      sched.push_back(v);
      mp00 = mp00 + 16'(v.a0) * 16'(v.b0);
      mp01 = mp01 + 16'(v.a0) * 16'(v.b1);
      mp10 = mp10 + 16'(v.a1) * 16'(v.b0);
      mp11 = mp11 + 16'(v.a1) * 16'(v.b1);
    end
    for (int i = 0; i < MAC_LAT; i++) begin
      v = '0; v.busy = 1'b1; v.k = KW'(kk);
      sched.push_back(v);
    end
    v = '0; v.busy = 1'b1; v.k = KW'(kk); v.done = 1'b1;
    sched.push_back(v);
    job.delete();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      job.delete();
      sched.delete();
      cur = idle_vec(0);
      started = 1;
    end else if (started) begin
      if (in_if.in_valid && cur.in_ready) begin
        job.push_back({in_if.in_a0, in_if.in_a1, in_if.in_b0, in_if.in_b1});
        if (in_if.in_last || job.size() == DEPTH) build_job();
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else                  cur = idle_vec(job.size());
    end
  end

  // ---------------- per-cycle compare + array emulation ----------------
  logic [15:0] acc00, acc01, acc10, acc11;
  int          done_cnt = 0;
  int          en_cnt   = 0;
  vec_t        dv;

  always @(negedge clk) begin
    if (started) begin
      dv = {in_if.in_ready, busy, acc_clr, en_mac, done, k_count, a0, a1, b0, b1};
      checks++;
      if (dv !== cur) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got rdy=%b busy=%b clr=%b en=%b done=%b k=%0d ab=%h required rdy=%b busy=%b clr=%b en=%b done=%b k=%0d ab=%h",
                 $time, dv.in_ready, dv.busy, dv.acc_clr, dv.en_mac, dv.done, dv.k,
                 {dv.a0, dv.a1, dv.b0, dv.b1}, cur.in_ready, cur.busy, cur.acc_clr,
                 cur.en_mac, cur.done, cur.k, {cur.a0, cur.a1, cur.b0, cur.b1});
      end
      if (rst || acc_clr) begin
        acc00 = '0; acc01 = '0; acc10 = '0; acc11 = '0;
        en_cnt = 0;
      end
      if (en_mac === 1'b1) begin
        acc00 = acc00 + 16'(a0) * 16'(b0);
        acc01 = acc01 + 16'(a0) * 16'(b1);
        acc10 = acc10 + 16'(a1) * 16'(b0);
        acc11 = acc11 + 16'(a1) * 16'(b1);
        en_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if ({acc00, acc01, acc10, acc11} !== {mp00, mp01, mp10, mp11}) begin
          errors++;
          $display("FAIL array_result t=%0t got %0d %0d %0d %0d required %0d %0d %0d %0d",
                   $time, acc00, acc01, acc10, acc11, mp00, mp01, mp10, mp11);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge
  task automatic send(input logic [4*DW-1:0] d, input logic last, input int gap);
    logic r;
    int   n = 0;
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    {in_if.in_a0, in_if.in_a1, in_if.in_b0, in_if.in_b1} = d;
    in_if.in_last  = last;
    in_if.in_valid = 1'b1;
    forever begin
      @(negedge clk); r = in_if.in_ready;
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n > 200) begin
        $display("FAIL accept_timeout t=%0t got no accept required accept", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
      end
    end
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
  endtask

  // Counts negedges after the last accept until done; realigns to posedge+#1
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(negedge clk); lat++;
      if (done === 1'b1) break;
      if (lat > 200) begin
        errors++;
        $display("FAIL done_timeout got no done required done");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_job(input int k, input int maxgap);
    for (int i = 0; i < k; i++) begin
      send($urandom, (i == k - 1), $urandom_range(0, maxgap));
    end
  endtask

  int lat, dc0;
  logic [4*DW-1:0] held;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    in_if.in_a0 = '0; in_if.in_a1 = '0; in_if.in_b0 = '0; in_if.in_b1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", int'(in_if.in_ready), 1);
    chk("reset_k_count", int'(k_count), 0);

    // K=2 known job
    send(32'h01020304, 1'b0, 0);
    send(32'h05060708, 1'b1, 0);
    wait_done(lat);
    chk("k2_latency", lat, 1 + 2 + MAC_LAT + 1);
    chk("k2_p00", int'(mp00), 38);
    chk("k2_p01", int'(mp01), 44);
    chk("k2_p10", int'(mp10), 48);
    chk("k2_p11", int'(mp11), 56);

    // K=1 job
    send(32'h03040506, 1'b1, 1);
    wait_done(lat);
    chk("k1_latency", lat, 1 + 1 + MAC_LAT + 1);
    chk("k1_p00", int'(mp00), 15);
    chk("k1_p11", int'(mp11), 24);

    // Full buffer, no in_last
    dc0 = done_cnt;
    for (int i = 0; i < DEPTH; i++) send($urandom, 1'b0, 0);
    chk("full_busy_after_16", int'(busy), 1);
    wait_done(lat);
    chk("full_latency", lat, 1 + DEPTH + MAC_LAT + 1);
    chk("full_en_cycles", en_cnt, DEPTH);
    chk("full_done_once", done_cnt - dc0, 1);

    // in_valid held high through RUN/DRAIN/DONE
    send($urandom, 1'b0, 0);
    send($urandom, 1'b1, 0);
    held = 32'hA1B2C3D4;
    {in_if.in_a0, in_if.in_a1, in_if.in_b0, in_if.in_b1} = held;
    in_if.in_valid = 1'b1;
    wait_done(lat);
    send(held, 1'b0, 0);
    chk("held_k_count", int'(k_count), 1);
    send(32'h01010101, 1'b1, 0);
    wait_done(lat);

    // Reset on RUN cycle 1 of a K=4 job
    dc0 = done_cnt;
    rand_job(4, 0);
    lat = 0;
    forever begin
      @(negedge clk);
      if (en_mac === 1'b1) lat++;
      if (lat == 2) break;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL run_wait got busy=%b required 1", busy);
        break;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_en_mac", int'(en_mac), 0);
    chk("abort_in_ready", int'(in_if.in_ready), 1);
    chk("abort_k_count", int'(k_count), 0);
    repeat (10) @(posedge clk);
    #1 chk("abort_no_done", done_cnt - dc0, 0);

    // Two back-to-back K=3 jobs with gaps
    dc0 = done_cnt;
    rand_job(3, 3);
    wait_done(lat);
    rand_job(3, 3);
    wait_done(lat);
    chk("two_jobs_done", done_cnt - dc0, 2);

    // Random jobs
    for (int j = 0; j < 12; j++) begin
      rand_job($urandom_range(1, DEPTH), 2);
      wait_done(lat);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
